fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameters: RESET_PC, default 32'h0, first fetch address; RAS_DEPTH, default 8, return-address-stack entries (power of two, 2..16).
REQ-002 SHALL have ports (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  imem_req  out  1  instruction fetch request
  imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ack=0
  imem_ack  in  1  imem_rdata valid this cycle
  imem_rdata  in  32  fetched word
  instruction  out  32  IF/ID instruction to decode
  PC4  out  32  IF/ID PC+4 to decode
  if_valid  out  1  IF/ID slot holds a live instruction
  id_stall  in  1  decode cannot accept; hold IF/ID
  id_PC4  in  32  PC+4 of the instruction now in decode, used as return address
  branchAddress, jumpAddress, callRs1Address  in  32 each  targets from decode
  SIG_EQ, SIG_BEQ, SIG_BNE, SIG_Jump, SIG_Call, SIG_CALL_RS1, SIG_RET  in  1 each  decode control
  ras_err  out  1  sticky RAS overflow/underflow flag

Function
REQ-003 Redirect SHALL be asserted when if_valid=1, id_stall=0 and any of: SIG_RET; SIG_CALL_RS1; SIG_Call; SIG_Jump; SIG_BEQ&SIG_EQ; SIG_BNE&~SIG_EQ.
REQ-004 Target priority SHALL be RET (RAS top) > CALL_RS1 (callRs1Address) > Call/Jump (jumpAddress) > branch (branchAddress).
REQ-005 SIG_Call and SIG_CALL_RS1 SHALL push id_PC4 onto the RAS; SIG_RET SHALL pop; each exactly once per redirect cycle.
REQ-006 FSM states SHALL be FETCH (request outstanding), HOLD (word buffered, decode stalled), DRAIN (discard one in-flight word after redirect).
REQ-007 In FETCH with imem_ack=1, no redirect and id_stall=0: IF/ID <= {imem_rdata, PC+4}, if_valid<=1, PC<=PC+4, stay FETCH; imem_req stays 1 (back-to-back fetch, throughput 1/cycle at zero wait states).
REQ-008 In FETCH with imem_ack=1 and id_stall=1: word and PC+4 SHALL be captured in a one-entry skid buffer, PC<=PC+4, imem_req<=0, go HOLD; IF/ID unchanged.
REQ-009 In HOLD on id_stall=0: skid buffer SHALL move to IF/ID, imem_req<=1, go FETCH.
REQ-010 On redirect in FETCH with imem_ack=1: arriving word discarded, PC<=target, if_valid<=0, stay FETCH, next request to target the following cycle.
REQ-011 On redirect in FETCH with imem_ack=0: target latched into PC_pending, go DRAIN; imem_addr held until ack; that ack discarded, then PC<=PC_pending, go FETCH; if_valid<=0 on the redirect cycle.
REQ-012 Redirect SHALL not occur in HOLD (id_stall=1 blocks it by REQ-003).
REQ-013 RAS SHALL be circular: push when full overwrites the oldest entry, count saturates at RAS_DEPTH; pop when empty returns 32'h0, count stays 0.
REQ-014 PC and all address arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFFFFFC+4 wraps to 0.

Reset
REQ-015 While rst_n=0 (asynchronous): PC=RESET_PC, state=FETCH, imem_req=0, instruction=0, PC4=0, if_valid=0, RAS count=0, ras_err=0, skid and PC_pending cleared.
REQ-016 imem_req SHALL rise on the first clk edge after rst_n deasserts; reset mid-request abandons it and any later ack for it is ignored.

Configuration
REQ-017 With FETCH_RAS_ERR_EN defined: ras_err SHALL set on push-when-full or pop-when-empty and clear only on reset.
REQ-018 Without FETCH_RAS_ERR_EN: ras_err SHALL be tied 0 and no detection logic generated; port remains present.

Structure
REQ-019 Shared package SHALL hold the FSM state enum (FETCH, HOLD, DRAIN), the redirect-source enum, and the RESET_PC default.
REQ-020 RAS SHALL be a separate sub-module ras_stack (push, pop, push_data, top, full, empty).

Verification
REQ-021 Reset release, ack every cycle, rdata=k: imem_addr 0,4,8,...; PC4 4,8,12; if_valid=1 from second edge.
REQ-022 SIG_BEQ=1, SIG_EQ=1, branchAddress=32'h40, ack same cycle: next imem_addr=32'h40, if_valid=0 one cycle; with SIG_EQ=0 no redirect.
REQ-023 SIG_Call, jumpAddress=32'h100, id_PC4=32'h14; later SIG_RET: fetch 32'h100 then 32'h14.
REQ-024 Redirect to 32'h80 while ack delayed 3 cycles: imem_addr held, late word dropped, next request 32'h80.
REQ-025 id_stall=1 as ack arrives with rdata=32'hDEADBEEF: IF/ID unchanged, imem_req=0; stall release -> instruction=32'hDEADBEEF.
REQ-026 Nine calls then ten returns (RAS_DEPTH=8): returns yield last 8 addresses then 0; ras_err=1 only with FETCH_RAS_ERR_EN.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: FSM states, redirect sources, the IF/ID word and the default reset PC.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN
  } fetchState_t;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_RET,
    SRC_CALL_RS1,
    SRC_JUMP,
    SRC_BRANCH
  } redirSrc_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;

  function automatic logic [31:0] nextPc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push when full overwrites the oldest entry, pop when empty reads 0.
// Updates on the clock edge; top/full/empty reflect current contents with no stall path.
module ras_stack #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic [31:0] top,
  output logic        full,
  output logic        empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] topPtr;
  logic [PW-1:0] wrIdx;
  logic [CW-1:0] count;
  logic          replaceTop;

  assign topPtr     = wrPtr - 1'b1;
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign top        = empty ? 32'h0 : mem[topPtr];
  // Simultaneous push and pop on a non-empty stack rewrites the top in place.
  assign replaceTop = push && pop && !empty;
  assign wrIdx      = replaceTop ? topPtr : wrPtr;

  always_ff @(posedge clk) begin
    if (push) mem[wrIdx] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      count <= '0;
    end else if (push && !replaceTop) begin
      wrPtr <= wrPtr + 1'b1;
      if (!full) count <= count + 1'b1;
    end else if (pop && !push && !empty) begin
      wrPtr <= topPtr;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: one word/cycle at zero wait, one-entry skid on decode stall (imem_req drops), RAS return targets.
// Redirect without ack drains the in-flight word first; FETCH_RAS_ERR_EN enables the sticky ras_err flag.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] PC4,
  output logic        if_valid,
  input  logic        id_stall,
  input  logic [31:0] id_PC4,
  input  logic [31:0] branchAddress,
  input  logic [31:0] jumpAddress,
  input  logic [31:0] callRs1Address,
  input  logic        SIG_EQ,
  input  logic        SIG_BEQ,
  input  logic        SIG_BNE,
  input  logic        SIG_Jump,
  input  logic        SIG_Call,
  input  logic        SIG_CALL_RS1,
  input  logic        SIG_RET,
  output logic        ras_err
);

  fetchState_t state;
  redirSrc_t   redirSrc;
  ifid_t       ifid;
  ifid_t       skid;
  logic [31:0] pcReg;
  logic [31:0] pcPending;
  logic [31:0] target;
  logic [31:0] rasTop;
  logic        reqReg;
  logic        ifValid;
  logic        takeBranch;
  logic        redirect;
  logic        ackLive;
  logic        rasPush;
  logic        rasPop;
  logic        rasFull;
  logic        rasEmpty;

  assign imem_req    = reqReg;
  assign imem_addr   = pcReg;
  assign instruction = ifid.instr;
  assign PC4         = ifid.pc4;
  assign if_valid    = ifValid;

  // An ack only counts against a request we actually have outstanding.
  assign ackLive    = reqReg && imem_ack;
  assign takeBranch = (SIG_BEQ && SIG_EQ) || (SIG_BNE && !SIG_EQ);

  always_comb begin
    redirSrc = SRC_NONE;
    target   = branchAddress;
    if (SIG_RET) begin
      redirSrc = SRC_RET;
      target   = rasTop;
    end else if (SIG_CALL_RS1) begin
      redirSrc = SRC_CALL_RS1;
      target   = callRs1Address;
    end else if (SIG_Call || SIG_Jump) begin
      redirSrc = SRC_JUMP;
      target   = jumpAddress;
    end else if (takeBranch) begin
      redirSrc = SRC_BRANCH;
    end
  end

  assign redirect = ifValid && !id_stall && (redirSrc != SRC_NONE);
  assign rasPush  = redirect && (SIG_Call || SIG_CALL_RS1);
  assign rasPop   = redirect && SIG_RET;

  ras_stack #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rasPush),
    .pop       (rasPop),
    .push_data (id_PC4),
    .top       (rasTop),
    .full      (rasFull),
    .empty     (rasEmpty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pcReg     <= RESET_PC;
      pcPending <= '0;
      reqReg    <= 1'b0;
      ifid      <= '0;
      skid      <= '0;
      ifValid   <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (!reqReg) reqReg <= 1'b1;
          if (redirect) begin
            ifValid <= 1'b0;
            if (ackLive) begin
              pcReg <= target;
            end else begin
              pcPending <= target;
              state     <= DRAIN;
            end
          end else if (ackLive && id_stall) begin
            skid   <= {imem_rdata, nextPc(pcReg)};
            pcReg  <= nextPc(pcReg);
            reqReg <= 1'b0;
            state  <= HOLD;
          end else if (ackLive) begin
            ifid    <= {imem_rdata, nextPc(pcReg)};
            ifValid <= 1'b1;
            pcReg   <= nextPc(pcReg);
          end else if (!id_stall) begin
            ifValid <= 1'b0;
          end
        end
        HOLD: begin
          if (!id_stall) begin
            reqReg <= 1'b1;
            state  <= FETCH;
            // Decode resolving a redirect on release makes the skid word wrong-path.
            if (redirect) begin
              ifValid <= 1'b0;
              pcReg   <= target;
            end else begin
              ifid    <= skid;
              ifValid <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (ackLive) begin
            pcReg <= pcPending;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_RAS_ERR_EN
  logic rasErr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rasErr <= 1'b0;
    end else if ((rasPush && !rasPop && rasFull) || (rasPop && rasEmpty)) begin
      rasErr <= 1'b1;
    end
  end
  assign ras_err = rasErr;
`else
  logic unusedRasFlags;
  assign unusedRasFlags = &{1'b0, rasFull, rasEmpty};
  assign ras_err        = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed literal scenarios then randomized traffic against a queue-based reference model.
module tb_fetch_unit;

  localparam int RAS_DEPTH = 8;
`ifdef FETCH_RAS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruction;
  logic [31:0] PC4;
  logic        if_valid;
  logic        id_stall = 1'b0;
  logic [31:0] id_PC4 = '0;
  logic [31:0] branchAddress = '0;
  logic [31:0] jumpAddress = '0;
  logic [31:0] callRs1Address = '0;
  logic        SIG_EQ = 1'b0, SIG_BEQ = 1'b0, SIG_BNE = 1'b0, SIG_Jump = 1'b0;
  logic        SIG_Call = 1'b0, SIG_CALL_RS1 = 1'b0, SIG_RET = 1'b0;
  logic        ras_err;

  int vectors = 0;
  int miscompares = 0;
  bit memAuto = 1'b1;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .PC4(PC4), .if_valid(if_valid),
    .id_stall(id_stall), .id_PC4(id_PC4),
    .branchAddress(branchAddress), .jumpAddress(jumpAddress), .callRs1Address(callRs1Address),
    .SIG_EQ(SIG_EQ), .SIG_BEQ(SIG_BEQ), .SIG_BNE(SIG_BNE), .SIG_Jump(SIG_Jump),
    .SIG_Call(SIG_Call), .SIG_CALL_RS1(SIG_CALL_RS1), .SIG_RET(SIG_RET),
    .ras_err(ras_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the fetch unit seen as a request stream plus queues.
  bit          mReq, mValid, mErr;
  logic [31:0] mPc, mInstr, mPc4;
  logic [63:0] mSkid[$];
  logic [31:0] mDrain[$];
  logic [31:0] mRas[$];

  always @(posedge clk or negedge rst_n) begin : model
    bit          ack, taken;
    logic [31:0] tgt, rtop;
    logic [63:0] w;
    if (!rst_n) begin
      mReq = 0; mValid = 0; mErr = 0;
      mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0;
      mSkid.delete(); mDrain.delete(); mRas.delete();
    end else begin
      ack   = mReq && imem_ack;
      rtop  = (mRas.size() != 0) ? mRas[$] : 32'h0;
      taken = mValid && !id_stall && (SIG_RET || SIG_CALL_RS1 || SIG_Call || SIG_Jump ||
              (SIG_BEQ && SIG_EQ) || (SIG_BNE && !SIG_EQ));
      tgt   = SIG_RET ? rtop : SIG_CALL_RS1 ? callRs1Address :
              (SIG_Call || SIG_Jump) ? jumpAddress : branchAddress;
      if (taken && SIG_RET) begin
        if (mRas.size() == 0) mErr = mErr | ERR_EN;
        else void'(mRas.pop_back());
      end
      if (taken && (SIG_Call || SIG_CALL_RS1)) begin
        if (mRas.size() == RAS_DEPTH) begin
          mErr = mErr | ERR_EN;
          void'(mRas.pop_front());
        end
        mRas.push_back(id_PC4);
      end
      if (mSkid.size() != 0) begin
        if (!id_stall) begin
          w = mSkid.pop_front();
          mReq = 1;
          if (taken) begin mValid = 0; mPc = tgt; end
          else begin mInstr = w[63:32]; mPc4 = w[31:0]; mValid = 1; end
        end
      end else if (!mReq) begin
        mReq = 1;
      end else if (mDrain.size() != 0) begin
        if (ack) mPc = mDrain.pop_front();
      end else if (taken) begin
        mValid = 0;
        if (ack) mPc = tgt; else mDrain.push_back(tgt);
      end else if (ack) begin
        if (id_stall) begin
          mSkid.push_back({imem_rdata, mPc + 32'd4});
          mReq = 0;
        end else begin
          mInstr = imem_rdata; mPc4 = mPc + 32'd4; mValid = 1;
        end
        mPc = mPc + 32'd4;
      end else if (!id_stall) begin
        mValid = 0;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    chk("imem_req", imem_req, mReq);
    if (mReq) chk("imem_addr", imem_addr, mPc);
    chk("if_valid", if_valid, mValid);
    if (mValid) begin
      chk("instruction", instruction, mInstr);
      chk("PC4", PC4, mPc4);
    end
    chk("ras_err", ras_err, mErr);
  end

  task automatic tick();
    @(negedge clk);
    if (memAuto) imem_rdata = ~imem_addr;
  endtask

  task automatic clearCtl();
    SIG_EQ = 0; SIG_BEQ = 0; SIG_BNE = 0; SIG_Jump = 0;
    SIG_Call = 0; SIG_CALL_RS1 = 0; SIG_RET = 0;
  endtask

  task automatic waitValid();
    int n = 0;
    while (!if_valid && n < 10) begin tick(); n++; end
    chk("wait_if_valid", if_valid, 1);
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] a = $urandom;
    if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC;
    return {a[31:2], 2'b00};
  endfunction

  initial begin
    imem_ack = 1;
    tick(); tick();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_pc4", PC4, 32'h0);
    chk("rst_ras_err", ras_err, 0);
    rst_n = 1;
    tick();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid", if_valid, 0);
    tick();
    chk("seq_valid", if_valid, 1);
    chk("seq_pc4_4", PC4, 32'h4);
    chk("model_pin_pc4", mPc4, 32'h4);
    chk("seq_instr0", instruction, 32'hFFFF_FFFF);
    chk("seq_addr_4", imem_addr, 32'h4);
    tick();
    chk("seq_pc4_8", PC4, 32'h8);
    chk("seq_addr_8", imem_addr, 32'h8);
    tick();
    chk("seq_pc4_12", PC4, 32'hC);

    SIG_BEQ = 1; SIG_EQ = 1; branchAddress = 32'h40;
    tick(); clearCtl();
    chk("beq_addr", imem_addr, 32'h40);
    chk("beq_bubble", if_valid, 0);
    tick();
    chk("beq_land_valid", if_valid, 1);
    chk("beq_land_pc4", PC4, 32'h44);
    SIG_BEQ = 1; SIG_EQ = 0; branchAddress = 32'h40;
    tick(); clearCtl();
    chk("beq_nt_addr", imem_addr, 32'h48);
    chk("beq_nt_pc4", PC4, 32'h48);

    SIG_Call = 1; jumpAddress = 32'h100; id_PC4 = 32'h14;
    tick(); clearCtl();
    chk("call_addr", imem_addr, 32'h100);
    tick();
    chk("call_land_pc4", PC4, 32'h104);
    SIG_RET = 1;
    tick(); clearCtl();
    chk("ret_addr", imem_addr, 32'h14);

    tick();
    SIG_Jump = 1; jumpAddress = 32'hFFFF_FFFC;
    tick(); clearCtl();
    chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc4", PC4, 32'h0);
    chk("wrap_next_addr", imem_addr, 32'h0);

    imem_ack = 0; SIG_Jump = 1; jumpAddress = 32'h80;
    tick(); clearCtl();
    chk("drain_hold0", imem_addr, 32'h0);
    chk("drain_bubble", if_valid, 0);
    tick();
    chk("drain_hold1", imem_addr, 32'h0);
    tick();
    chk("drain_hold2", imem_addr, 32'h0);
    chk("drain_req", imem_req, 1);
    imem_ack = 1;
    tick();
    chk("drain_redirect", imem_addr, 32'h80);
    chk("drain_drop", if_valid, 0);

    tick();
    memAuto = 0; imem_rdata = 32'hDEAD_BEEF; id_stall = 1;
    tick();
    chk("stall_req", imem_req, 0);
    chk("stall_instr", instruction, 32'hFFFF_FF7F);
    chk("stall_pc4", PC4, 32'h84);
    imem_ack = 0;
    tick();
    chk("stall_hold_req", imem_req, 0);
    id_stall = 0;
    tick();
    chk("skid_instr", instruction, 32'hDEAD_BEEF);
    chk("skid_pc4", PC4, 32'h88);
    chk("skid_req", imem_req, 1);
    chk("skid_addr", imem_addr, 32'h88);
    memAuto = 1; imem_ack = 1; imem_rdata = ~imem_addr;

    for (int i = 0; i < 9; i++) begin
      waitValid();
      SIG_Call = 1; jumpAddress = 32'h1000 + 32'(i) * 32'h100; id_PC4 = 32'h2000 + 32'(i) * 32'd4;
      tick(); clearCtl();
      chk("call_n_addr", imem_addr, 32'h1000 + 32'(i) * 32'h100);
    end
    chk("ras_err_after_calls", ras_err, ERR_EN);
    for (int j = 0; j < 10; j++) begin
      waitValid();
      SIG_RET = 1;
      tick(); clearCtl();
      chk("ret_n_addr", imem_addr, (j < 8) ? 32'h2000 + 32'(8 - j) * 32'd4 : 32'h0);
    end
    chk("ras_err_after_rets", ras_err, ERR_EN);

    memAuto = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst_n = 0; imem_ack = 1; clearCtl();
        tick();
        rst_n = 1;
      end
      imem_rdata = $urandom;
      imem_ack = mReq && ($urandom_range(0, 9) < 7);
      id_stall = ($urandom_range(0, 3) == 0);
      clearCtl();
      SIG_EQ = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 11))
        0: SIG_RET = 1;
        1: SIG_CALL_RS1 = 1;
        2: SIG_Call = 1;
        3: SIG_Jump = 1;
        4: SIG_BEQ = 1;
        5: SIG_BNE = 1;
        default: ;
      endcase
      branchAddress = randAddr();
      jumpAddress = randAddr();
      callRs1Address = randAddr();
      id_PC4 = randAddr();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
